// File: rtl/array_ctrl_pkg.sv
// ============================================================================
// Module   : array_ctrl_pkg
// Brief    : Shared types, default sizes and phase-length helpers for the
//            systolic-array sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package array_ctrl_pkg;

    // Default array geometry and reduction limit
    localparam int ARR_HEIGHT = 12;
    localparam int ARR_WIDTH  = 14;
    localparam int ARR_KMAX   = 1024;

    // Width of the reduction-length port and of the phase counter
    localparam int KW = $clog2(ARR_KMAX + 1);
    localparam int CW = $clog2(ARR_KMAX + ARR_HEIGHT + ARR_WIDTH + 1);

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Weight load: one cycle per row so the weights ripple down every row
    function automatic int load_len(input int height);
        return height;
    endfunction

    // Input streaming: k values per row, plus the row skew of the last row
    function automatic int compute_len(input int k, input int height);
        return k + height - 1;
    endfunction

    // Output drain: HEIGHT results per column, plus the column skew
    function automatic int drain_len(input int width, input int height);
        return width + height - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/array_ctrl_skew.sv
// ============================================================================
// Module   : array_ctrl_skew
// Brief    : Skewed window decoder. Lane i is enabled while
//            i <= c < i + len and flagged as first on c == i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_ctrl_skew #(
    parameter int N  = 12,
    parameter int CW = 11
) (
    input  logic [CW-1:0] c,
    input  logic [CW-1:0] len,
    input  logic          gate,
    output logic [N-1:0]  win,
    output logic [N-1:0]  first
);

    // One comparator pair per lane; lane offset equals its index
    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            localparam logic [CW-1:0] c_idx = CW'(i);
            assign win[i]   = gate && (c >= c_idx) && (c < (c_idx + len));
            assign first[i] = gate && (c == c_idx);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/array_ctrl.sv
// ============================================================================
// Module   : array_ctrl
// Brief    : Tile sequencer for the weight-stationary systolic array.
//            Per accepted start: weight load, skewed input streaming,
//            skewed output drain, then a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_ctrl #(
    parameter int HEIGHT = array_ctrl_pkg::ARR_HEIGHT,
    parameter int WIDTH  = array_ctrl_pkg::ARR_WIDTH,
    parameter int KMAX   = array_ctrl_pkg::ARR_KMAX,
    parameter int KW     = $clog2(KMAX + 1),
    parameter int CW     = $clog2(KMAX + HEIGHT + WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KW-1:0]     k_len,
    input  logic              stall,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [WIDTH-1:0]  en_w,
    output logic [WIDTH-1:0]  clr_w,
    output logic [HEIGHT-1:0] en_i,
    output logic [HEIGHT-1:0] clr_i,
    output logic [WIDTH-1:0]  en_o,
    output logic [WIDTH-1:0]  clr_o
);

    import array_ctrl_pkg::*;

    state_t          state_q, state_d;
    logic [CW-1:0]   c_q, c_d;
    logic [KW-1:0]   k_q, k_d;
    logic            cfg_err_q, cfg_err_d;

    logic [CW-1:0]   w_last;
    logic            w_phase_end;
    logic            w_gate_w;
    logic            w_gate_i;
    logic            w_gate_o;

    // Last counter value of the current phase
    always_comb begin
        w_last = '0;
        case (state_q)
            LOAD_W:  w_last = CW'(load_len(HEIGHT) - 1);
            COMPUTE: w_last = CW'(compute_len(32'(k_q), HEIGHT) - 1);
            DRAIN:   w_last = CW'(drain_len(WIDTH, HEIGHT) - 1);
            default: w_last = '0;
        endcase
    end

    assign w_phase_end = (c_q == w_last);

    // Next-state, counter, tile length and config-error decode
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        k_d       = k_q;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        k_d     = k_len;
                        state_d = LOAD_W;
                        c_d     = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            LOAD_W, COMPUTE, DRAIN: begin
                // abort outranks both stall and phase completion
                if (abort) begin
                    state_d = IDLE;
                    c_d     = '0;
                end else if (!stall) begin
                    if (w_phase_end) begin
                        c_d = '0;
                        case (state_q)
                            LOAD_W:  state_d = COMPUTE;
                            COMPUTE: state_d = DRAIN;
                            default: state_d = DONE;
                        endcase
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                c_d     = '0;
            end
            default: begin
                state_d = IDLE;
                c_d     = '0;
            end
        endcase
    end

    // State, counter and captured tile length registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            c_q       <= '0;
            k_q       <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            k_q       <= k_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Status outputs
    assign ready   = (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign cfg_err = cfg_err_q;

    // A stall blanks every enable and clear; since c holds, a pending clear
    // reappears with its enable on the first unstalled cycle.
    assign w_gate_w = (state_q == LOAD_W)  && !stall;
    assign w_gate_i = (state_q == COMPUTE) && !stall;
    assign w_gate_o = (state_q == DRAIN)   && !stall;

    assign en_w  = {WIDTH{w_gate_w}};
    assign clr_w = {WIDTH{w_gate_w && (c_q == '0)}};

    array_ctrl_skew #(
        .N  (HEIGHT),
        .CW (CW)
    ) u_skew_i (
        .c     (c_q),
        .len   (CW'(k_q)),
        .gate  (w_gate_i),
        .win   (en_i),
        .first (clr_i)
    );

    array_ctrl_skew #(
        .N  (WIDTH),
        .CW (CW)
    ) u_skew_o (
        .c     (c_q),
        .len   (CW'(HEIGHT)),
        .gate  (w_gate_o),
        .win   (en_o),
        .first (clr_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_array_ctrl.sv
// ============================================================================
// Module   : tb_array_ctrl
// Brief    : Scoreboard bench for array_ctrl (12 x 14 array, KMAX 1024).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [10:0] k_len;
    logic        stall;
    logic        abort;
    logic        ready;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [13:0] en_w;
    logic [13:0] clr_w;
    logic [11:0] en_i;
    logic [11:0] clr_i;
    logic [13:0] en_o;
    logic [13:0] clr_o;

    array_ctrl u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .k_len   (k_len),
        .stall   (stall),
        .abort   (abort),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err),
        .en_w    (en_w),
        .clr_w   (clr_w),
        .en_i    (en_i),
        .clr_i   (clr_i),
        .en_o    (en_o),
        .clr_o   (clr_o)
    );

    // Clock and cycle index (cycle n = interval after the n-th rising edge)
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected pulse events and expected output snapshots
    typedef struct packed {
        int         cyc;
        logic [1:0] kind;   // {done, cfg_err}
    } ev_t;

    typedef struct packed {
        int          cyc;
        logic [81:0] v;     // {ready, busy, en_w, clr_w, en_i, clr_i, en_o, clr_o}
    } samp_t;

    ev_t   evq[$];
    samp_t sq[$];

    int total = 0;
    int bad   = 0;
    logic end_check = 1'b0;
    logic end_done  = 1'b0;

    localparam logic [13:0] F14 = 14'h3FFF;

    task automatic ev(input int c, input logic [1:0] kind);
        ev_t e;
        e.cyc  = c;
        e.kind = kind;
        evq.push_back(e);
    endtask

    task automatic chk(input int c, input logic rdy, input logic bsy,
                       input logic [13:0] ew, input logic [13:0] cw,
                       input logic [11:0] ei, input logic [11:0] ci,
                       input logic [13:0] eo, input logic [13:0] co);
        samp_t s;
        s.cyc = c;
        s.v   = {rdy, bsy, ew, cw, ei, ci, eo, co};
        sq.push_back(s);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares pulses against the event queue and snapshots
    // against the sample queue, mid-cycle on the falling edge
    always @(negedge clk) begin
        logic [81:0] got;
        ev_t   e;
        samp_t s;
        got = {ready, busy, en_w, clr_w, en_i, clr_i, en_o, clr_o};
        if (done || cfg_err) begin
            total++;
            if (evq.size() == 0) begin
                bad++;
                $display("FAIL pulse_unexpected cyc=%0d got={done,cfg_err}=%b required none",
                         cyc, {done, cfg_err});
            end else begin
                e = evq.pop_front();
                if (e.cyc != cyc || e.kind != {done, cfg_err}) begin
                    bad++;
                    $display("FAIL pulse cyc=%0d got={done,cfg_err}=%b required %b at cyc=%0d",
                             cyc, {done, cfg_err}, e.kind, e.cyc);
                end
            end
        end
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
            s = sq.pop_front();
            total++;
            if (got !== s.v) begin
                bad++;
                $display("FAIL snapshot cyc=%0d got=%h required=%h", cyc, got, s.v);
            end
        end
        if (end_check && !end_done) begin
            total++;
            if (evq.size() != 0) begin
                bad++;
                $display("FAIL pulses_missing got=%0d pending required 0", evq.size());
            end
            total++;
            if (sq.size() != 0) begin
                bad++;
                $display("FAIL snapshots_missing got=%0d pending required 0", sq.size());
            end
            end_done = 1'b1;
        end
    end

    int t;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        k_len = '0;
        stall = 1'b0;
        abort = 1'b0;

        // Reset state, held and released
        tick(3);
        t = cyc;
        chk(t, 1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        chk(t + 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick(2);

        // Tile with k=4: 53 busy cycles, window boundaries per phase
        t = cyc;
        start = 1'b1;
        k_len = 11'd4;
        chk(t,      1, 0, 0,   0,   0,      0,      0,       0);
        chk(t + 1,  0, 1, F14, F14, 0,      0,      0,       0);
        chk(t + 2,  0, 1, F14, 0,   0,      0,      0,       0);
        chk(t + 13, 0, 1, 0,   0,   12'h001, 12'h001, 0,     0);
        chk(t + 16, 0, 1, 0,   0,   12'h00F, 12'h008, 0,     0);
        chk(t + 17, 0, 1, 0,   0,   12'h01E, 12'h010, 0,     0);
        chk(t + 24, 0, 1, 0,   0,   12'hF00, 12'h800, 0,     0);
        chk(t + 27, 0, 1, 0,   0,   12'h800, 12'h000, 0,     0);
        chk(t + 28, 0, 1, 0,   0,   0,      0,      14'h0001, 14'h0001);
        chk(t + 30, 0, 1, 0,   0,   0,      0,      14'h0007, 14'h0004);
        chk(t + 41, 0, 1, 0,   0,   0,      0,      14'h3FFC, 14'h2000);
        chk(t + 52, 0, 1, 0,   0,   0,      0,      14'h2000, 14'h0000);
        chk(t + 53, 0, 1, 0,   0,   0,      0,      0,       0);
        chk(t + 54, 1, 0, 0,   0,   0,      0,      0,       0);
        ev(t + 53, 2'b10);
        tick(1);
        start = 1'b0;
        tick(55);

        // Stall 3 cycles at COMPUTE c=5: busy grows to 56
        t = cyc;
        start = 1'b1;
        k_len = 11'd4;
        chk(t + 17, 0, 1, 0, 0, 12'h01E, 12'h010, 0, 0);
        chk(t + 18, 0, 1, 0, 0, 0,       0,       0, 0);
        chk(t + 20, 0, 1, 0, 0, 0,       0,       0, 0);
        chk(t + 21, 0, 1, 0, 0, 12'h03C, 12'h020, 0, 0);
        chk(t + 56, 0, 1, 0, 0, 0,       0,       0, 0);
        chk(t + 57, 1, 0, 0, 0, 0,       0,       0, 0);
        ev(t + 56, 2'b10);
        tick(1);
        start = 1'b0;
        tick(17);
        stall = 1'b1;
        tick(3);
        stall = 1'b0;
        tick(40);

        // Stall 2 cycles at DRAIN c=2: clr_o[2] issued exactly once afterwards
        t = cyc;
        start = 1'b1;
        k_len = 11'd4;
        chk(t + 29, 0, 1, 0, 0, 0, 0, 14'h0003, 14'h0002);
        chk(t + 30, 0, 1, 0, 0, 0, 0, 14'h0000, 14'h0000);
        chk(t + 31, 0, 1, 0, 0, 0, 0, 14'h0000, 14'h0000);
        chk(t + 32, 0, 1, 0, 0, 0, 0, 14'h0007, 14'h0004);
        chk(t + 33, 0, 1, 0, 0, 0, 0, 14'h000F, 14'h0008);
        ev(t + 55, 2'b10);
        tick(1);
        start = 1'b0;
        tick(29);
        stall = 1'b1;
        tick(2);
        stall = 1'b0;
        tick(30);

        // k_len=0 rejected; then starts during COMPUTE are ignored
        t = cyc;
        start = 1'b1;
        k_len = 11'd0;
        ev(t + 1, 2'b01);
        chk(t + 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick(1);
        start = 1'b0;
        tick(1);
        start = 1'b1;
        k_len = 11'd4;
        chk(t + 19, 0, 1, 0, 0, 12'h01E, 12'h010, 0, 0);
        chk(t + 22, 0, 1, 0, 0, 12'h0F0, 12'h080, 0, 0);
        chk(t + 29, 0, 1, 0, 0, 12'h800, 12'h000, 0, 0);
        ev(t + 55, 2'b10);
        tick(1);
        start = 1'b0;
        tick(13);
        start = 1'b1;
        k_len = 11'd9;
        tick(1);
        k_len = 11'd0;
        tick(1);
        start = 1'b0;
        tick(45);

        // abort at LOAD_W c=7: enables intact that cycle, then IDLE, no done
        t = cyc;
        start = 1'b1;
        k_len = 11'd4;
        chk(t + 8, 0, 1, F14, 0, 0, 0, 0, 0);
        chk(t + 9, 1, 0, 0,   0, 0, 0, 0, 0);
        tick(1);
        start = 1'b0;
        tick(7);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(10);

        // Asynchronous reset in the middle of DRAIN
        t = cyc;
        start = 1'b1;
        k_len = 11'd4;
        chk(t + 32, 0, 1, 0, 0, 0, 0, 14'h001F, 14'h0010);
        chk(t + 33, 1, 0, 0, 0, 0, 0, 0,        0);
        chk(t + 36, 1, 0, 0, 0, 0, 0, 0,        0);
        tick(1);
        start = 1'b0;
        tick(32);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);

        end_check = 1'b1;
        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
